// File: rtl/mux_nx1_scan.sv
// N-to-1 registered multiplexer with manual select and an auto-scan mode that
// dwells DWELL cycles on each enabled channel, skipping disabled ones with wrap.
module mux_nx1_scan #(
  parameter int N     = 4,
  parameter int W     = 1,
  parameter int DWELL = 4,
  localparam int SW   = (N <= 2) ? 1 : $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*W-1:0]  i_data,
  input  logic            mode,
  input  logic [SW-1:0]   sel,
  input  logic [N-1:0]    en_mask,
  output logic [W-1:0]    y,
  output logic            y_valid,
  output logic [SW-1:0]   cur_sel,
  output logic [1:0]      dbg_state
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    SCAN   = 2'd1,
    EMPTY  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   cur_sel_q, cur_sel_d;
  logic [W-1:0]    y_q, y_d;
  logic            y_valid_q, y_valid_d;

  logic [SW-1:0]   sel_c;
  logic [SW-1:0]   idx;
  logic [SW-1:0]   nxt;
  logic            found;
  logic            hold;
  logic [SW-1:0]   c;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_sel_d = cur_sel_q;
    y_d       = y_q;
    y_valid_d = y_valid_q;
    sel_c     = sel;
    idx       = '0;
    nxt       = cur_sel_q;
    found     = 1'b0;
    hold      = 1'b0;
    c         = cur_sel_q;

    if (int'(sel) >= N) sel_c = SW'(N - 1);

    // Search starts just past the current channel and ends on it, so a lone
    // enabled channel finds itself.
    for (int i = 1; i <= N; i++) begin
      idx = SW'((int'(cur_sel_q) + i) % N);
      if (!found && en_mask[idx]) begin
        found = 1'b1;
        nxt   = idx;
      end
    end

    hold = en_mask[cur_sel_q] &&
           !(state_q == SCAN && cnt_q == CW'(DWELL - 1));
    c    = hold ? cur_sel_q : nxt;

    if (!mode) begin
      state_d   = MANUAL;
      cur_sel_d = sel_c;
      y_d       = i_data[int'(sel_c)*W +: W];
      y_valid_d = 1'b1;
      cnt_d     = '0;
    end else if (en_mask == '0) begin
      state_d   = EMPTY;
      y_d       = '0;
      y_valid_d = 1'b0;
      cnt_d     = '0;
    end else begin
      state_d   = SCAN;
      cur_sel_d = c;
      y_d       = i_data[int'(c)*W +: W];
      y_valid_d = 1'b1;
      // Counting continues only while already scanning and staying put.
      cnt_d     = (state_q == SCAN && hold) ? cnt_q + CW'(1) : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= MANUAL;
      cnt_q     <= '0;
      cur_sel_q <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_sel_q <= cur_sel_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign y         = y_q;
  assign y_valid   = y_valid_q;
  assign cur_sel   = cur_sel_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mux_nx1_scan.sv
// Directed bench for mux_nx1_scan with N=4, W=4, DWELL=3 and channels D,C,B,A.
module tb_mux_nx1_scan;

  localparam int N = 4;
  localparam int W = 4;
  localparam int DWELL = 3;
  localparam int SW = 2;

  localparam logic [1:0] ST_MANUAL = 2'd0;
  localparam logic [1:0] ST_SCAN   = 2'd1;
  localparam logic [1:0] ST_EMPTY  = 2'd2;

  logic           clk;
  logic           rst;
  logic [N*W-1:0] i_data;
  logic           mode;
  logic [SW-1:0]  sel;
  logic [N-1:0]   en_mask;
  logic [W-1:0]   y;
  logic           y_valid;
  logic [SW-1:0]  cur_sel;
  logic [1:0]     dbg_state;

  int tests_run;
  int tests_failed;

  mux_nx1_scan #(.N(N), .W(W), .DWELL(DWELL)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_data   (i_data),
    .mode     (mode),
    .sel      (sel),
    .en_mask  (en_mask),
    .y        (y),
    .y_valid  (y_valid),
    .cur_sel  (cur_sel),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // one rising edge, then sample on the falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_out(input string tag, input logic [3:0] ey, input logic ev,
                            input logic [1:0] ecs);
    check({tag, ".y"}, 32'(y), 32'(ey));
    check({tag, ".y_valid"}, 32'(y_valid), 32'(ev));
    check({tag, ".cur_sel"}, 32'(cur_sel), 32'(ecs));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // hand-written y sequences
  logic [3:0] seq_all [13] = '{4'hA,4'hA,4'hA,4'hB,4'hB,4'hB,4'hC,4'hC,4'hC,4'hD,4'hD,4'hD,4'hA};
  logic [1:0] cs_all  [13] = '{0,0,0,1,1,1,2,2,2,3,3,3,0};
  logic [3:0] seq_odd [7]  = '{4'hB,4'hB,4'hB,4'hD,4'hD,4'hD,4'hB};
  logic [1:0] cs_odd  [7]  = '{1,1,1,3,3,3,1};
  logic [3:0] seq_mid [7]  = '{4'hA,4'hB,4'hB,4'hC,4'hC,4'hC,4'hD};
  logic [1:0] cs_mid  [7]  = '{0,1,1,2,2,2,3};

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst     = 1'b1;
    i_data  = 16'hDCBA;
    mode    = 1'b0;
    sel     = 2'd0;
    en_mask = 4'b0000;
    #12;
    expect_out("reset", 4'h0, 1'b0, 2'd0);
    check("reset.state", 32'(dbg_state), 32'(ST_MANUAL));

    // manual select, one-cycle latency
    @(negedge clk);
    rst = 1'b0;
    sel = 2'd2;
    step();
    expect_out("man_sel2", 4'hC, 1'b1, 2'd2);
    sel = 2'd1;
    step();
    expect_out("man_sel1", 4'hB, 1'b1, 2'd1);
    sel = 2'd3;
    i_data = 16'h5CBA;
    step();
    expect_out("man_sel3", 4'h5, 1'b1, 2'd3);
    i_data = 16'hDCBA;

    // full scan from reset
    do_reset();
    mode = 1'b1;
    en_mask = 4'b1111;
    for (int i = 0; i < 13; i++) begin
      step();
      expect_out($sformatf("scan_all[%0d]", i), seq_all[i], 1'b1, cs_all[i]);
    end
    check("scan_all.state", 32'(dbg_state), 32'(ST_SCAN));

    // asynchronous reset mid-dwell
    step();
    #2 rst = 1'b1;
    #1;
    expect_out("async_rst", 4'h0, 1'b0, 2'd0);
    check("async_rst.state", 32'(dbg_state), 32'(ST_MANUAL));
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      expect_out($sformatf("post_rst[%0d]", i), seq_all[i], 1'b1, cs_all[i]);
    end

    // skip disabled channels with wrap
    do_reset();
    en_mask = 4'b1010;
    for (int i = 0; i < 7; i++) begin
      step();
      expect_out($sformatf("scan_odd[%0d]", i), seq_odd[i], 1'b1, cs_odd[i]);
    end

    // empty mask holds cur_sel, then single channel C
    en_mask = 4'b0000;
    step();
    expect_out("empty", 4'h0, 1'b0, 2'd1);
    check("empty.state", 32'(dbg_state), 32'(ST_EMPTY));
    en_mask = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      step();
      expect_out($sformatf("only_c[%0d]", i), 4'hC, 1'b1, 2'd2);
    end

    // only channel A enabled
    en_mask = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      step();
      expect_out($sformatf("only_a[%0d]", i), 4'hA, 1'b1, 2'd0);
    end

    // re-enable all, then drop channel B mid-dwell
    en_mask = 4'b1111;
    for (int i = 0; i < 7; i++) begin
      if (i == 3) en_mask = 4'b1101;
      step();
      expect_out($sformatf("drop_b[%0d]", i), seq_mid[i], 1'b1, cs_mid[i]);
    end

    // scan -> manual -> scan resumes from cur_sel with a fresh dwell
    mode = 1'b0;
    sel  = 2'd0;
    step();
    expect_out("to_manual", 4'hA, 1'b1, 2'd0);
    check("to_manual.state", 32'(dbg_state), 32'(ST_MANUAL));
    mode = 1'b1;
    en_mask = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      step();
      expect_out($sformatf("resume[%0d]", i), seq_all[i], 1'b1, cs_all[i]);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
